// File: rtl/mc_pkg.sv
// mc_pkg: state encodings, opcodes and datapath select constants for the multi-cycle control FSM
package mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEM       = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
endpackage

// File: rtl/multicycle_control.sv
// multicycle_control: RV32I multi-cycle main control FSM with memory timeout; MC_ILLEGAL_TRAP_EN adds the TRAP state and illegal_instr
module multicycle_control
  import mc_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       bus_timeout,
  output logic [3:0] state_o
`ifdef MC_ILLEGAL_TRAP_EN
  ,
  output logic       illegal_instr
`endif
);
`ifdef MC_ILLEGAL_TRAP_EN
  localparam state_e ILLEGAL_NXT = S_TRAP;
`else
  localparam state_e ILLEGAL_NXT = S_FETCH;
`endif
  state_e state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic stall, timeout;
  // state register and memory wait counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // next state, wait counting and timeout abort back to FETCH
  always_comb begin
    stall   = (state_q inside {S_FETCH, S_MEMREAD, S_MEMWRITE}) && !mem_ready;
    timeout = stall && (MAX_WAIT != 0) && (cnt_q == WAIT_W'(MAX_WAIT));
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = ILLEGAL_NXT;
        endcase
      S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
    if (timeout) state_d = S_FETCH;
    cnt_d = (stall && !timeout) ? (&cnt_q ? cnt_q : cnt_q + 1'b1) : '0;
  end
  // Moore decode, qualified by mem_ready/zero, with timeout suppression and asynchronous reset gating of strobes
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    result_src = RES_ALUOUT;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_SUB;
        pc_write  = zero;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
    bus_timeout = timeout && !reset;
    if (timeout || reset) begin
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      mem_we    = 1'b0;
      reg_write = 1'b0;
    end
    if (reset) mem_req = 1'b0;
  end
  assign state_o = state_q;
`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal_instr = (state_q == S_TRAP);
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized instruction-level reference model check of the multi-cycle control FSM
module tb_multicycle_control;
  localparam int MAXW = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  logic mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, bus_timeout;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [3:0] state_o;
`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_instr;
`endif
  logic [18:0] obs;
  int n_checks = 0;
  int n_fail = 0;
  int path[$];
  int idx = 0;
  int waitc = 0;
  int stall_kind = 0;
  logic [6:0] op_cur = 7'd0;

  multicycle_control #(.MAX_WAIT(MAXW), .WAIT_W(3)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
    .bus_timeout(bus_timeout), .state_o(state_o)
`ifdef MC_ILLEGAL_TRAP_EN
    , .illegal_instr(illegal_instr)
`endif
  );

  always #5 clk = ~clk;

  assign obs = {state_o, bus_timeout, mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, alu_op, result_src};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected output word for one state, straight from the per-state output table
  function automatic logic [18:0] expect_outs(input int st, input logic mr, input logic z, input logic to);
    logic req, we, adr, irw, pcw, rw;
    logic [1:0] a, b, op, rs;
    {req, we, adr, irw, pcw, rw} = 6'b0;
    {a, b, op, rs} = 8'b0;
    case (st)
      0: begin req = 1; b = 2; rs = 2; irw = mr; pcw = mr; end
      1: begin a = 1; b = 1; end
      2: begin a = 2; b = 1; end
      3: begin req = 1; adr = 1; end
      4: begin rs = 1; rw = 1; end
      5: begin req = 1; we = 1; adr = 1; end
      6: begin a = 2; op = 2; end
      7: begin a = 2; b = 1; op = 2; end
      8: rw = 1;
      9: begin a = 2; op = 1; pcw = z; end
      10: begin a = 1; b = 2; pcw = 1; end
      default: ;
    endcase
    if (to) {irw, pcw, we, rw} = 4'b0;
    return {4'(st), to, req, we, adr, irw, pcw, rw, a, b, op, rs};
  endfunction

  // Pick the next instruction and the state sequence it must walk through
  task automatic new_instr();
    int k;
`ifdef MC_ILLEGAL_TRAP_EN
    k = $urandom_range(0, 5);
`else
    k = $urandom_range(0, 6);
`endif
    stall_kind = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
    idx = 0;
    case (k)
      0: begin op_cur = 7'b0000011; path = {0, 1, 2, 3, 4}; end
      1: begin op_cur = 7'b0100011; path = {0, 1, 2, 5}; end
      2: begin op_cur = 7'b0110011; path = {0, 1, 6, 8}; end
      3: begin op_cur = 7'b0010011; path = {0, 1, 7, 8}; end
      4: begin op_cur = 7'b1100011; path = {0, 1, 9}; end
      5: begin op_cur = 7'b1101111; path = {0, 1, 10, 8}; end
      default: begin
        op_cur = 7'($urandom);
        if (op_cur inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111})
          op_cur = 7'b1111111;
        path = {0, 1};
      end
    endcase
  endtask

  initial begin
    int cur;
    logic mem_st, to;
    mem_ready = 1'b1;
    opcode = 7'b0110011;
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", 32'(state_o), 32'd0);
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_ir_write", 32'(ir_write), 32'd0);
    check("reset_pc_write", 32'(pc_write), 32'd0);
    check("reset_strobes", 32'({mem_we, reg_write, bus_timeout}), 32'd0);
    check("reset_selects", 32'({adr_src, alu_src_a, alu_src_b, alu_op, result_src}), 32'b0_00_10_00_10);
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    new_instr();
    for (int c = 0; c < 4000; c++) begin
      cur = path[idx];
      mem_st = (cur == 0) || (cur == 3) || (cur == 5);
      opcode = op_cur;
      zero = 1'($urandom_range(0, 1));
      mem_ready = ((stall_kind == 1 && cur == 0) || (stall_kind == 2 && cur != 0)) ? 1'b0
                  : ($urandom_range(0, 2) != 0);
      to = mem_st && !mem_ready && (waitc == MAXW);
      #1 check("outs", 32'(obs), 32'(expect_outs(cur, mem_ready, zero, to)));
      if (to) begin
        waitc = 0;
        new_instr();
      end else if (mem_st && !mem_ready) begin
        waitc++;
      end else begin
        waitc = 0;
        idx++;
        if (idx == path.size()) new_instr();
      end
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    opcode = 7'b0100011;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("sw_state", 32'(state_o), 32'd5);
    check("sw_we", 32'({mem_req, mem_we}), 32'b11);
    #2 reset = 1'b1;
    #1;
    check("async_req", 32'(mem_req), 32'd0);
    check("async_we", 32'(mem_we), 32'd0);
    check("async_state", 32'(state_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("post_reset_state", 32'(state_o), 32'd0);
`ifdef MC_ILLEGAL_TRAP_EN
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    opcode = 7'b1111111;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("trap_state", 32'(state_o), 32'd11);
    check("trap_flag", 32'(illegal_instr), 32'd1);
    repeat (5) @(negedge clk);
    #1;
    check("trap_hold", 32'(state_o), 32'd11);
    check("trap_strobes", 32'({mem_req, mem_we, ir_write, pc_write, reg_write}), 32'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
